// File: rtl/mult32_seq_ctrl.sv
// Sequences a 32x32 unsigned multiply through a shared 16x16 core; result valid 5 cycles after accept.
// Output holds in DONE until out_ready; no new operands are taken until the result has been consumed.
module mult32_seq_ctrl #(
  parameter int HW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*HW-1:0] in_a,
  input  logic [2*HW-1:0] in_b,
  output logic [HW-1:0]   mul_a,
  output logic [HW-1:0]   mul_b,
  output logic            mul_en,
  input  logic [2*HW-1:0] mul_p,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*HW-1:0] out_p,
  output logic            busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [2*HW-1:0] a_q, b_q;
  logic [4*HW-1:0] acc_q, acc_d;
  logic [4*HW-1:0] pp_ext;

  // Zero-extend the core product so the shifted adds stay exact in 64 bits.
  assign pp_ext = {{(2*HW){1'b0}}, mul_p};

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mul_a     = '0;
    mul_b     = '0;
    mul_en    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S0;
      end
      S0: begin
        mul_a   = a_q[HW-1:0];
        mul_b   = b_q[HW-1:0];
        mul_en  = 1'b1;
        acc_d   = pp_ext;
        state_d = S1;
      end
      S1: begin
        mul_a   = a_q[HW-1:0];
        mul_b   = b_q[2*HW-1:HW];
        mul_en  = 1'b1;
        acc_d   = acc_q + (pp_ext << HW);
        state_d = S2;
      end
      S2: begin
        mul_a   = a_q[2*HW-1:HW];
        mul_b   = b_q[HW-1:0];
        mul_en  = 1'b1;
        acc_d   = acc_q + (pp_ext << HW);
        state_d = S3;
      end
      S3: begin
        mul_a   = a_q[2*HW-1:HW];
        mul_b   = b_q[2*HW-1:HW];
        mul_en  = 1'b1;
        acc_d   = acc_q + (pp_ext << (2*HW));
        state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  // Operand registers carry no reset; they are only read after a fresh accept.
  always_ff @(posedge clk) begin
    if (rst_n && state_q == IDLE && in_valid) begin
      a_q <= in_a;
      b_q <= in_b;
    end
  end

  assign out_p = acc_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed bench for mult32_seq_ctrl with a behavioural 16x16 core; inputs driven and outputs sampled on the falling edge.
module tb_mult32_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  mult32_seq_ctrl #(.HW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_en    (mul_en),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_a = 32'h1111_2222; in_b = 32'h3333_4444; out_ready = 1'b0;
    cyc();
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy_in_reset: got %b want 0", busy); end
    cyc();
    rst_n = 1'b1; in_valid = 1'b0;
    vec_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mul_en !== 1'b0 ||
        mul_a !== 16'h0 || mul_b !== 16'h0 || out_p !== 64'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: rdy=%b ov=%b busy=%b en=%b a=%h b=%h p=%h want 1 0 0 0 0 0 0",
               in_ready, out_valid, busy, mul_en, mul_a, mul_b, out_p);
    end
    cyc();
    vec_cnt++;
    if (busy !== 1'b0 || mul_en !== 1'b0) begin
      err_cnt++; $display("FAIL reset_no_accept: busy=%b en=%b want 0 0", busy, mul_en);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ea [4];
    logic [15:0] eb [4];
    ea = '{16'h0002, 16'h0002, 16'h0001, 16'h0001};
    eb = '{16'h0004, 16'h0003, 16'h0004, 16'h0003};
    in_a = 32'h0001_0002; in_b = 32'h0003_0004; in_valid = 1'b1; out_ready = 1'b1;
    vec_cnt++;
    if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_accept: in_ready=%b want 1", in_ready); end
    cyc();
    in_valid = 1'b0; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (mul_a !== ea[i] || mul_b !== eb[i] || mul_en !== 1'b1) begin
        err_cnt++;
        $display("FAIL basic_step%0d: a=%h b=%h en=%b want %h %h 1", i, mul_a, mul_b, mul_en, ea[i], eb[i]);
      end
      cyc();
    end
    vec_cnt++;
    if (out_valid !== 1'b1 || out_p !== 64'h0000_0003_000A_0008 || in_ready !== 1'b0 || mul_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_result: ov=%b p=%h rdy=%b en=%b want 1 0000_0003_000a_0008 0 0",
               out_valid, out_p, in_ready, mul_en);
    end
    cyc();
    vec_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL basic_idle: ov=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_max_operands();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] vp [3];
    va = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
    vp = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h0000_0001_FFFF_FFFE};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = va[i]; in_b = vb[i]; in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) cyc();
      vec_cnt++;
      if (out_valid !== 1'b1 || out_p !== vp[i]) begin
        err_cnt++; $display("FAIL max_vec%0d: ov=%b p=%h want 1 %h", i, out_valid, out_p, vp[i]);
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    in_a = 32'h0000_1000; in_b = 32'h0000_0100; in_valid = 1'b1; out_ready = 1'b0;
    cyc();
    in_a = 32'hDEAD_BEEF; in_b = 32'hCAFE_F00D;
    for (int c = 1; c < 5; c++) cyc();
    for (int c = 5; c <= 8; c++) begin
      vec_cnt++;
      if (out_valid !== 1'b1 || out_p !== 64'h0000_0000_0010_0000 || in_ready !== 1'b0) begin
        err_cnt++;
        $display("FAIL stall_cycle%0d: ov=%b p=%h rdy=%b want 1 0000_0000_0010_0000 0", c, out_valid, out_p, in_ready);
      end
      cyc();
    end
    out_ready = 1'b1;
    vec_cnt++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL stall_handshake: ov=%b rdy=%b want 1 0", out_valid, in_ready);
    end
    cyc();
    in_a = 32'h0001_0000; in_b = 32'h0001_0000;
    vec_cnt++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL stall_idle: rdy=%b busy=%b want 1 0", in_ready, busy);
    end
    cyc();
    in_valid = 1'b0;
    vec_cnt++;
    if (busy !== 1'b1 || mul_en !== 1'b1) begin
      err_cnt++; $display("FAIL stall_reaccept: busy=%b en=%b want 1 1", busy, mul_en);
    end
    for (int c = 11; c < 15; c++) cyc();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_p !== 64'h0000_0001_0000_0000) begin
      err_cnt++; $display("FAIL stall_second: ov=%b p=%h want 1 0000_0001_0000_0000", out_valid, out_p);
    end
    cyc();
  endtask

  task automatic test_reset_midop();
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    vec_cnt++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || out_p !== 64'h0) begin
      err_cnt++;
      $display("FAIL midop_reset: busy=%b rdy=%b ov=%b p=%h want 0 1 0 0", busy, in_ready, out_valid, out_p);
    end
    for (int c = 0; c < 6; c++) begin
      cyc();
      vec_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        err_cnt++; $display("FAIL midop_quiet%0d: ov=%b busy=%b want 0 0", c, out_valid, busy);
      end
    end
    in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int c = 1; c < 5; c++) cyc();
    vec_cnt++;
    if (out_valid !== 1'b1 || out_p !== 64'h0B00_EA4E_242D_2080) begin
      err_cnt++; $display("FAIL midop_after: ov=%b p=%h want 1 0b00_ea4e_242d_2080", out_valid, out_p);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] p1, p2;
    int en_cnt;
    a1 = 32'h8000_0001; b1 = 32'h0000_0003;
    a2 = 32'hABCD_0000; b2 = 32'h0001_FFFF;
    p1 = {32'b0, a1} * {32'b0, b1};
    p2 = {32'b0, a2} * {32'b0, b2};
    en_cnt = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_a = a1; in_b = b1;
    for (int c = 0; c <= 12; c++) begin
      if (mul_en === 1'b1) en_cnt++;
      if (c == 0 || c == 6) begin
        vec_cnt++;
        if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept%0d: rdy=%b want 1", c, in_ready); end
      end
      if (c == 5 || c == 11) begin
        vec_cnt++;
        if (out_valid !== 1'b1 || out_p !== ((c == 5) ? p1 : p2)) begin
          err_cnt++;
          $display("FAIL b2b_result%0d: ov=%b p=%h want 1 %h", c, out_valid, out_p, (c == 5) ? p1 : p2);
        end
      end
      if (c == 1) begin in_a = a2; in_b = b2; end
      if (c == 7) in_valid = 1'b0;
      cyc();
    end
    vec_cnt++;
    if (en_cnt != 8) begin err_cnt++; $display("FAIL b2b_mul_en_count: got %0d want 8", en_cnt); end
    vec_cnt++;
    if (busy !== 1'b0) begin err_cnt++; $display("FAIL b2b_final_idle: busy=%b want 0", busy); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    cyc();
    test_reset();
    test_basic();
    test_max_operands();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
